// File: rtl/safecrack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : safecrack_pkg
//  Purpose  : Shared constants and types for the safe-cracking lock front end.
//  Revision : 1.0 - initial release
// ============================================================================
package safecrack_pkg;

  localparam int unsigned CLK_HZ              = 50_000_000;
  // 20 ms stable-input window at CLK_HZ
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 50;

  typedef enum logic [1:0] {
    DB_IDLE         = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_HELD         = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } dbnc_state_t;

endpackage : safecrack_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_channel
//  Purpose  : Two-flop synchroniser plus debounce FSM for one active-low button.
//  Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
  import safecrack_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_press,
  output logic o_fire
);

  localparam int unsigned        CNT_W      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  dbnc_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             w_cnt_done;

  assign w_cnt_done = (r_cnt == c_cnt_last);
  // Same condition that loads r_press; lets the top register its flags in step
  assign o_fire     = (r_state == DB_PRESS_WAIT) && !r_sync2 && w_cnt_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= DB_IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      case (r_state)
        DB_IDLE: begin
          if (!r_sync2) begin
            r_state <= DB_PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        DB_PRESS_WAIT: begin
          if (r_sync2) begin
            r_state <= DB_IDLE;
          end else if (w_cnt_done) begin
            r_state <= DB_HELD;
            r_level <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DB_HELD: begin
          if (r_sync2) begin
            r_state <= DB_RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        DB_RELEASE_WAIT: begin
          if (!r_sync2) begin
            r_state <= DB_HELD;
          end else if (w_cnt_done) begin
            r_state <= DB_IDLE;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= DB_IDLE;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Debounced levels, press pulses and press flags for NUM_BTN buttons.
//  Revision : 1.0 - initial release
// ============================================================================
module button_conditioner
  import safecrack_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic               press_valid,
  output logic               press_multi
);

  logic [NUM_BTN-1:0] w_fire;
  logic               r_valid;
  logic               r_multi;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .i_btn_n(btn_n[i]),
      .o_level(btn_level[i]),
      .o_press(btn_press[i]),
      .o_fire (w_fire[i])
    );
  end

  // x & (x-1) clears the lowest set bit, so non-zero means two or more presses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_valid <= |w_fire;
      r_multi <= |(w_fire & (w_fire - NUM_BTN'(1)));
    end
  end

  assign press_valid = r_valid;
  assign press_multi = r_multi;

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_conditioner
//  Purpose  : Self-checking bench for button_conditioner against a run-length model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int NB = 3;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_n = '1;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic          press_valid;
  logic          press_multi;

  int n_chk = 0;
  int n_err = 0;

  // Model: level flips once the delayed input disagrees with it for DB+1 samples
  logic [NB-1:0] m_dl1, m_dl2, m_level, m_press;
  int            m_run  [NB];
  int            pulse_cnt [NB];

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (btn_n),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .press_valid(press_valid),
    .press_multi(press_multi)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dl1   = '1;
    m_dl2   = '1;
    m_level = '0;
    m_press = '0;
    for (int i = 0; i < NB; i++) m_run[i] = 0;
  endtask

  task automatic check_outputs(input string where);
    check_eq({where, "/level"}, 8'(btn_level), 8'(m_level));
    check_eq({where, "/press"}, 8'(btn_press), 8'(m_press));
    check_eq({where, "/valid"}, 8'(press_valid), 8'(|m_press));
    check_eq({where, "/multi"}, 8'(press_multi), 8'($countones(m_press) > 1));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_press = '0;
      for (int i = 0; i < NB; i++) begin
        if ((!m_dl2[i]) != m_level[i]) m_run[i]++;
        else                           m_run[i] = 0;
        if (m_run[i] == DB + 1) begin
          m_level[i] = ~m_level[i];
          m_run[i]   = 0;
          m_press[i] = m_level[i];
        end
      end
      m_dl2 = m_dl1;
      m_dl1 = btn_n;
    end
    #1;
    for (int i = 0; i < NB; i++) pulse_cnt[i] += int'(btn_press[i]);
    check_outputs("cyc");
  endtask

  initial begin
    int k;
    logic saw;
    int hold [NB];
    for (int i = 0; i < NB; i++) pulse_cnt[i] = 0;
    model_reset();

    // 1: reset state and idle
    repeat (3) tick();
    check_eq("t1_reset", {btn_level, btn_press, press_valid, press_multi}, 8'd0);
    rst = 1'b0;
    repeat (50) tick();
    check_eq("t1_idle", {btn_level, btn_press, press_valid, press_multi}, 8'd0);

    // 2: single press latency
    btn_n[0] = 1'b0;
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      tick();
      if (btn_press[0]) k = i;
    end
    check_eq("t2_latency", 8'(k), 8'd11);
    check_eq("t2_press", 8'(btn_press), 8'b001);
    check_eq("t2_valid", 8'(press_valid), 8'd1);
    repeat (30 - k) tick();
    check_eq("t2_held", 8'(btn_level[0]), 8'd1);

    // 3: short glitch on channel 1
    btn_n[1] = 1'b0;
    repeat (5) tick();
    btn_n[1] = 1'b1;
    repeat (20) tick();
    check_eq("t3_nopulse", 8'(pulse_cnt[1]), 8'd0);
    check_eq("t3_level", 8'(btn_level[1]), 8'd0);

    // 4: release bounce on channel 0
    for (int i = 0; i < 6; i++) begin
      btn_n[0] = (i % 2 == 0);
      tick();
    end
    btn_n[0] = 1'b1;
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      tick();
      if (!btn_level[0]) k = i;
    end
    check_eq("t4_release", 8'(k), 8'd11);
    check_eq("t4_onepulse", 8'(pulse_cnt[0]), 8'd1);
    repeat (10) tick();

    // 5: simultaneous presses
    btn_n = 3'b010;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (btn_press == 3'b101 && press_multi && press_valid) saw = 1'b1;
    end
    check_eq("t5_multi", 8'(saw), 8'd1);
    check_eq("t5_pulses", 8'(pulse_cnt[0] + pulse_cnt[2]), 8'd3);
    btn_n = 3'b111;
    repeat (20) tick();

    // 6: reset in the middle of a press window
    btn_n[0] = 1'b0;
    repeat (20) tick();
    btn_n[2] = 1'b0;
    repeat (7) tick();
    #2;
    btn_n[0] = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("t6_async", {btn_level, btn_press, press_valid, press_multi}, 8'd0);
    repeat (3) tick();
    rst = 1'b0;
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      tick();
      if (btn_press != '0) k = i;
    end
    check_eq("t6_latency", 8'(k), 8'd11);
    check_eq("t6_press", 8'(btn_press), 8'b100);
    btn_n = 3'b111;
    repeat (20) tick();

    // Random hold lengths around the debounce window
    for (int i = 0; i < NB; i++) hold[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (hold[i] == 0) begin
          btn_n[i] = ~btn_n[i];
          hold[i]  = int'($urandom_range(1, 16));
        end
        hold[i]--;
      end
      tick();
    end
    btn_n = 3'b111;
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule : tb_button_conditioner
`default_nettype wire
